// File: rtl/deserializer.sv
// deserializer: rebuilds parallel words from an MSB-first serial bit stream.
// A word is emitted once DATA_W bits have arrived. A shorter burst is emitted
// as a left-aligned partial word when the first idle cycle follows it.
// deser_data_mod_o gives the number of valid bits, with 0 meaning DATA_W.
//
// Handshake: data_i is consumed on every rising edge where data_val_i is
// high, and there is no back-pressure. deser_data_val_o is a one-cycle strobe.
// deser_data_o and deser_data_mod_o are meaningful on that strobe and hold
// their values until the next one.
module deserializer #(
    parameter int DATA_W = 16,
    parameter int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic              data_i,
    input  logic              data_val_i,
    output logic [DATA_W-1:0] deser_data_o,
    output logic [MOD_W-1:0]  deser_data_mod_o,
    output logic              deser_data_val_o,
    output logic              busy_o
);

    // IDLE means no bits are held (cnt = 0); COLLECT means a word is in progress.
    typedef enum logic {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam logic [MOD_W-1:0] CNT_LAST = MOD_W'(DATA_W - 1);
    localparam logic [MOD_W:0]   WORD_LEN = (MOD_W + 1)'(DATA_W);

    state_t            state_q, state_d;
    logic [DATA_W-1:0] shreg_q, shreg_d;
    logic [MOD_W-1:0]  cnt_q,   cnt_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic [MOD_W-1:0]  mod_q,   mod_d;
    logic              val_q,   val_d;
    // Left shift that moves a partial word up to the MSB end.
    // cnt is never 0 when this value is used, so the range is 1..DATA_W-1.
    logic [MOD_W:0]    pad_bits;

    // Next-state logic: shift in a bit, close a full word, or flush a partial word at a gap.
    always_comb begin
        state_d  = state_q;
        shreg_d  = shreg_q;
        cnt_d    = cnt_q;
        data_d   = data_q;
        mod_d    = mod_q;
        val_d    = 1'b0;
        pad_bits = WORD_LEN - {1'b0, cnt_q};

        if (data_val_i) begin
            shreg_d = {shreg_q[DATA_W-2:0], data_i};
            cnt_d   = cnt_q + MOD_W'(1);
            state_d = COLLECT;
            if (cnt_q == CNT_LAST) begin
                // Full word. The counter wraps to 0 naturally, so a bit on the
                // very next edge starts a fresh word with no lost cycle.
                data_d  = shreg_d;
                mod_d   = '0;
                val_d   = 1'b1;
                state_d = IDLE;
            end
        end else if (state_q == COLLECT) begin
            // Gap after a short burst: left-align what has arrived and zero-fill the LSBs.
            data_d  = shreg_q << pad_bits;
            mod_d   = cnt_q;
            val_d   = 1'b1;
            cnt_d   = '0;
            shreg_d = '0;
            state_d = IDLE;
        end
    end

    // State and output registers. Reset discards any partial word without a strobe.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q <= IDLE;
            shreg_q <= '0;
            cnt_q   <= '0;
            data_q  <= '0;
            mod_q   <= '0;
            val_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shreg_q <= shreg_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            mod_q   <= mod_d;
            val_q   <= val_d;
        end
    end

    assign deser_data_o     = data_q;
    assign deser_data_mod_o = mod_q;
    assign deser_data_val_o = val_q;
    // busy_o is the registered FSM state: high while a word is being collected.
    assign busy_o           = (state_q == COLLECT);

endmodule

// File: tb/tb_deserializer.sv
// Testbench for deserializer: table-driven vectors, hand-written sequences
// for back-to-back and reset corner cases, and a random end-to-end run
// against a word-level model of the serializer.
module tb_deserializer;
    localparam int W  = 16;
    localparam int MW = 4;

    logic          clk = 1'b0;
    logic          srst_i = 1'b0;
    logic          data_i = 1'b0;
    logic          data_val_i = 1'b0;
    logic [W-1:0]  deser_data_o;
    logic [MW-1:0] deser_data_mod_o;
    logic          deser_data_val_o;
    logic          busy_o;

    deserializer #(.DATA_W(W), .MOD_W(MW)) dut (
        .clk_i            (clk),
        .srst_i           (srst_i),
        .data_i           (data_i),
        .data_val_i       (data_val_i),
        .deser_data_o     (deser_data_o),
        .deser_data_mod_o (deser_data_mod_o),
        .deser_data_val_o (deser_data_val_o),
        .busy_o           (busy_o)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- monitor ----------------
    typedef struct {
        logic [W-1:0]  data;
        logic [MW-1:0] mod;
        int            cyc;
    } rx_t;

    rx_t           got_q[$];
    logic          mon_en = 1'b0;
    logic [W-1:0]  last_data = '0;
    logic [MW-1:0] last_mod = '0;

    always @(negedge clk) begin
        if (mon_en) begin
            if (deser_data_val_o) begin
                chk("busy_low_in_strobe", 32'(busy_o), 32'd0);
                got_q.push_back('{deser_data_o, deser_data_mod_o, cyc});
                last_data = deser_data_o;
                last_mod  = deser_data_mod_o;
            end else begin
                chk("hold_data", 32'(deser_data_o), 32'(last_data));
                chk("hold_mod", 32'(deser_data_mod_o), 32'(last_mod));
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic drive(input logic b, input logic v);
        @(negedge clk);
        data_i     = b;
        data_val_i = v;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 1'b0);
    endtask

    // Sends the top n bits of w, MSB first.
    // last_cyc is the cycle count after the posedge that samples the last bit.
    task automatic send_word(input logic [W-1:0] w, input int n, output int last_cyc);
        for (int i = 0; i < n; i++) drive(w[W-1-i], 1'b1);
        last_cyc = cyc + 1;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_data"}, 32'(deser_data_o), 32'd0);
        chk({tag, "_mod"},  32'(deser_data_mod_o), 32'd0);
        chk({tag, "_val"},  32'(deser_data_val_o), 32'd0);
        chk({tag, "_busy"}, 32'(busy_o), 32'd0);
    endtask

    task automatic do_reset(input logic bit_during_reset);
        mon_en = 1'b0;
        @(negedge clk);
        srst_i     = 1'b1;
        data_val_i = bit_during_reset;
        data_i     = bit_during_reset;
        @(negedge clk);
        check_reset_outputs("reset");
        srst_i     = 1'b0;
        data_val_i = 1'b0;
        data_i     = 1'b0;
        last_data  = '0;
        last_mod   = '0;
        mon_en     = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic [W-1:0]  bits;
        int            nbits;
        logic [W-1:0]  exp_data;
        logic [MW-1:0] exp_mod;
        int            exp_lat;
    } vec_t;

    vec_t vecs[7];

    // Expected values for the random run, one queue entry per word sent.
    logic [W-1:0]  exp_q[$];
    logic [MW-1:0] exp_mod_q[$];

    initial begin : main
        int last_c;
        int lat;
        int n;
        int gap;
        logic [W-1:0]  w;
        logic [MW-1:0] m;
        logic [W-1:0]  keep_mask;

        vecs[0] = '{16'hA5C3, 16, 16'hA5C3, 4'd0,  1};
        vecs[1] = '{16'hB000, 5,  16'hB000, 4'd5,  2};
        vecs[2] = '{16'h8000, 1,  16'h8000, 4'd1,  2};
        vecs[3] = '{16'h0000, 1,  16'h0000, 4'd1,  2};
        vecs[4] = '{16'hFFFF, 15, 16'hFFFE, 4'd15, 2};
        vecs[5] = '{16'h8001, 16, 16'h8001, 4'd0,  1};
        vecs[6] = '{16'h6FFF, 3,  16'h6000, 4'd3,  2};

        do_reset(1'b0);

        // Table-driven single words: value, count, latency and busy after the last bit.
        foreach (vecs[k]) begin
            got_q.delete();
            send_word(vecs[k].bits, vecs[k].nbits, last_c);
            drive(1'b0, 1'b0);
            chk($sformatf("vec%0d_busy_after_last", k), 32'(busy_o),
                32'(vecs[k].nbits != W));
            idle(4);
            chk($sformatf("vec%0d_count", k), got_q.size(), 1);
            if (got_q.size() > 0) begin
                lat = got_q[0].cyc - last_c + 1;
                chk($sformatf("vec%0d_data", k), 32'(got_q[0].data), 32'(vecs[k].exp_data));
                chk($sformatf("vec%0d_mod", k), 32'(got_q[0].mod), 32'(vecs[k].exp_mod));
                chk($sformatf("vec%0d_latency", k), lat, vecs[k].exp_lat);
            end
            chk($sformatf("vec%0d_busy_idle", k), 32'(busy_o), 32'd0);
        end

        // Back-to-back full words with no gap between them.
        got_q.delete();
        send_word(16'hFFFF, 16, last_c);
        send_word(16'h0001, 16, n);
        idle(4);
        chk("b2b_count", got_q.size(), 2);
        if (got_q.size() == 2) begin
            chk("b2b_data0", 32'(got_q[0].data), 32'h0000FFFF);
            chk("b2b_mod0", 32'(got_q[0].mod), 32'd0);
            chk("b2b_lat0", got_q[0].cyc - last_c + 1, 1);
            chk("b2b_data1", 32'(got_q[1].data), 32'h00000001);
            chk("b2b_mod1", 32'(got_q[1].mod), 32'd0);
            chk("b2b_spacing", got_q[1].cyc - got_q[0].cyc, 16);
        end
        chk("b2b_busy_idle", 32'(busy_o), 32'd0);

        // Reset in the middle of a word, with a valid bit on the reset edge.
        got_q.delete();
        send_word(16'hFF80, 9, last_c);
        do_reset(1'b1);
        send_word(16'h1234, 16, last_c);
        idle(4);
        chk("rst_mid_count", got_q.size(), 1);
        if (got_q.size() > 0) begin
            chk("rst_mid_data", 32'(got_q[0].data), 32'h00001234);
            chk("rst_mid_mod", 32'(got_q[0].mod), 32'd0);
        end

        // Random end-to-end run. The serializer is modelled at word level:
        // a word with mod m carries its top m bits, and 0 means all W bits.
        got_q.delete();
        exp_q.delete();
        exp_mod_q.delete();
        for (int t = 0; t < 80; t++) begin
            w = W'($urandom());
            if (t == 0) m = 4'd0;
            else if (t == 1) m = 4'd1;
            else m = MW'($urandom_range(0, W - 1));
            n = (m == 0) ? W : int'(m);
            keep_mask = '1;
            keep_mask = keep_mask << (W - n);
            exp_q.push_back(w & keep_mask);
            exp_mod_q.push_back(m);
            send_word(w, n, last_c);
            gap = (m == 0) ? $urandom_range(0, 2) : $urandom_range(1, 3);
            idle(gap);
        end
        idle(4);
        chk("rand_count", got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
            chk($sformatf("rand%0d_data", i), 32'(got_q[i].data), 32'(exp_q[i]));
            chk($sformatf("rand%0d_mod", i), 32'(got_q[i].mod), 32'(exp_mod_q[i]));
        end
        chk("rand_busy_idle", 32'(busy_o), 32'd0);

        mon_en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/deserializer.md
# deserializer

Serial-to-parallel stage downstream of the serializer. Samples the serializer's MSB-first bit stream, `ser_data_o` qualified by `ser_data_val_o`, and rebuilds parallel words. A full word is emitted after DATA_W bits; a shorter burst is emitted as a partial word, using the same bit-count encoding the serializer takes on `data_mod_i`. Sits between the serial link and the parallel consumer.

## Interface

- DATA_W, 16: word width in bits; must be a power of two, ≥ 2.
- MOD_W, $clog2(DATA_W): width of the bit-count field.
- clk_i  in  1  single clock; all logic on rising edge.
- srst_i  in  1  reset, synchronous and active-high.
- data_i  in  1  serial bit; MSB of the word arrives first.
- data_val_i  in  1  data_i valid this cycle.
- deser_data_o  out  DATA_W  reassembled word, left-aligned; unused LSBs are 0.
- deser_data_mod_o  out  MOD_W  number of valid bits in deser_data_o; 0 encodes DATA_W.
- deser_data_val_o  out  1  one-cycle strobe qualifying deser_data_o and deser_data_mod_o.
- busy_o  out  1  a partial word is being accumulated (bit count > 0).

## Operation

- Internal state:
  - shift register `shreg`, DATA_W bits;
  - bit counter `cnt`, range 0..DATA_W-1, MOD_W bits.
- FSM states:
  - IDLE: cnt = 0.
  - COLLECT: cnt > 0.
- Edge with data_val_i = 1:
  - shreg <= {shreg[DATA_W-2:0], data_i};
  - cnt <= cnt + 1, with natural MOD_W wrap.
- Full word, when data_val_i = 1 and cnt = DATA_W-1:
  - deser_data_o <= {shreg[DATA_W-2:0], data_i};
  - deser_data_mod_o <= 0, meaning DATA_W;
  - deser_data_val_o <= 1;
  - cnt wraps to 0; FSM goes to IDLE.
- Burst end, when data_val_i = 0 and cnt > 0:
  - deser_data_o <= shreg << (DATA_W - cnt), left-aligned with LSBs zero-filled;
  - deser_data_mod_o <= cnt; deser_data_val_o <= 1;
  - cnt <= 0; shreg <= 0; FSM goes to IDLE.
- data_val_i = 0 and cnt = 0: no action.
- deser_data_o and deser_data_mod_o hold their last emitted values until the next emission.
- deser_data_val_o is high for exactly one cycle per word.
- Simultaneous events:
  - The edge that completes a full word may be followed immediately by a new bit (back-to-back bursts, no gap).
  - The new bit starts the next word at cnt = 0. No bits are lost and no extra strobe is produced.
- A burst longer than DATA_W bits is split: one full word per DATA_W bits, and the remainder is emitted as a partial word at the gap.

## Timing

- Outputs are registered; there is no combinational path from input to output.
- Full word: deser_data_val_o is high in the cycle after the cycle carrying the last (DATA_W-th) bit. Latency is 1.
- Partial word: deser_data_val_o is high in the cycle after the first cycle with data_val_i = 0. That is 2 cycles after the last bit.
- busy_o is registered. It is high from the cycle after the first bit until the cycle in which the word strobe is high; busy_o is low in that strobe cycle.
- Throughput: one bit per cycle, sustained indefinitely.
- Reset values: deser_data_o = 0, deser_data_mod_o = 0, deser_data_val_o = 0, busy_o = 0; cnt = 0, shreg = 0, FSM = IDLE.
- Reset mid-word: the accumulated bits are discarded and no strobe is issued. If data_val_i = 1 on the reset edge, that bit is ignored.
- Reset has priority over every other event.

## Test plan

- Full word: 16 consecutive bits of 16'hA5C3, MSB first -> one strobe 1 cycle after the last bit; deser_data_o = 16'hA5C3, deser_data_mod_o = 0.
- Partial word: 5 bits 1,0,1,1,0 followed by a gap -> strobe 2 cycles after the last bit; deser_data_o = 16'hB000, deser_data_mod_o = 5.
- Back-to-back bursts: 16 bits of 16'hFFFF immediately followed by 16 bits of 16'h0001 with no gap -> two strobes exactly 16 cycles apart with the correct values; busy_o is never stuck high.
- Single bit: one bit of 1, then idle -> deser_data_o = 16'h8000, deser_data_mod_o = 1. A single bit of 0 -> 16'h0000, mod = 1.
- Reset mid-word: 9 bits, then srst_i high for 1 cycle, then 16 bits of 16'h1234 -> no strobe for the 9 bits; next strobe carries 16'h1234 with mod 0; all outputs are 0 during reset.
- End-to-end: serializer → deserializer over random data_i/data_mod_i, including mod = 0 and mod = 1 -> every word received equals the top mod bits of the word sent; deser_data_mod_o equals data_mod_i.
